alu_arbiter: RTL and testbench

- Shares one 8-bit combinational ALU (8-bit a/b operands, 4-bit sel opcode, 8-bit z result) between two requesters, r0 and r1.
- Each requester hands over an operation with a valid/ready handshake.
- The arbiter chooses between them round-robin, drives the ALU operand and opcode registers, and waits a programmable settle time. It then captures z and returns it to the owning requester with a one-cycle done pulse.
- Sits between the register-file/sequencer logic and the ALU instance.

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between two requesters.
// Holds the ALU inputs for ALU_LAT cycles, then returns z to the owner with a done pulse.
module alu_arbiter #(
  parameter int ALU_LAT = 1  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       r0_valid,
  output logic       r0_ready,
  input  logic [7:0] r0_a,
  input  logic [7:0] r0_b,
  input  logic [3:0] r0_sel,
  output logic [7:0] r0_z,
  output logic       r0_done,
  output logic       r0_err,

  input  logic       r1_valid,
  output logic       r1_ready,
  input  logic [7:0] r1_a,
  input  logic [7:0] r1_b,
  input  logic [3:0] r1_sel,
  output logic [7:0] r1_z,
  output logic       r1_done,
  output logic       r1_err,

  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_z,

  output logic       busy
);

  localparam logic [3:0] LAT         = 4'(ALU_LAT);
  localparam logic [3:0] SEL_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       owner;
  logic       last_grant;

  logic       grant;
  logic       accept;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] req_sel;
  logic       req_illegal;
  logic       capture;

  // Round-robin: a lone requester wins outright, a tie goes to the one not served last.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant = ~last_grant;
    unique case ({r1_valid, r0_valid})
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last_grant;
    endcase
  end

  assign r0_ready = (state == IDLE) && !grant;
  assign r1_ready = (state == IDLE) &&  grant;
  assign accept   = (r0_valid && r0_ready) || (r1_valid && r1_ready);

  assign req_a       = grant ? r1_a   : r0_a;
  assign req_b       = grant ? r1_b   : r0_b;
  assign req_sel     = grant ? r1_sel : r0_sel;
  assign req_illegal = (req_sel == SEL_ILLEGAL);

  // The last EXEC edge is the one on which alu_z has been stable for ALU_LAT cycles.
  assign capture = (state == EXEC) && (cnt == 4'd1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = req_illegal ? DONE : EXEC;
      EXEC: if (cnt == 4'd1) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        cnt        <= req_illegal ? 4'd0 : LAT;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Operands change only on an accept edge and otherwise hold the last issued operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= 8'h00;
      alu_b   <= 8'h00;
      alu_sel <= 4'h0;
    end else if (accept) begin
      alu_a   <= req_a;
      alu_b   <= req_b;
      alu_sel <= req_sel;
    end
  end

  // Per-requester result registers; only the owner's pair is ever written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_z   <= 8'h00;
      r0_err <= 1'b0;
      r1_z   <= 8'h00;
      r1_err <= 1'b0;
    end else if (accept && req_illegal) begin
      if (grant) begin
        r1_z   <= 8'h00;
        r1_err <= 1'b1;
      end else begin
        r0_z   <= 8'h00;
        r0_err <= 1'b1;
      end
    end else if (capture) begin
      if (owner) begin
        r1_z   <= alu_z;
        r1_err <= 1'b0;
      end else begin
        r0_z   <= alu_z;
        r0_err <= 1'b0;
      end
    end
  end

  assign r0_done = (state == DONE) && !owner;
  assign r1_done = (state == DONE) &&  owner;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT=1 and 3) share one stimulus stream and
// are each compared every cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0_valid, r1_valid;
  logic [7:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0] r0_sel, r1_sel;

  logic [1:0] r0_ready, r1_ready, r0_done, r1_done, r0_err, r1_err, busy;
  logic [7:0] r0_z [2];
  logic [7:0] r1_z [2];
  logic [7:0] alu_a [2];
  logic [7:0] alu_b [2];
  logic [3:0] alu_sel [2];
  logic [7:0] alu_z [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Reference ALU (the block the arbiter feeds); results are 8-bit, wrap-around.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s);
    logic [7:0] r;
    case (s)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a * b;
      4'h4: r = a | b;
      4'h5: r = ~a;
      4'h6: r = a << 1;
      4'h7: r = a >> 1;
      4'h8: r = ~(a & b);
      4'h9: r = ~(a | b);
      4'hA: r = a ^ b;
      4'hB: r = ~(a ^ b);
      4'hC: r = {7'd0, &a};
      4'hD: r = {7'd0, |a};
      4'hE: r = {7'd0, ^a};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign alu_z[0] = alu_f(alu_a[0], alu_b[0], alu_sel[0]);
  assign alu_z[1] = alu_f(alu_a[1], alu_b[1], alu_sel[1]);

  alu_arbiter #(.ALU_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready[0]), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
    .r0_z(r0_z[0]), .r0_done(r0_done[0]), .r0_err(r0_err[0]),
    .r1_valid(r1_valid), .r1_ready(r1_ready[0]), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
    .r1_z(r1_z[0]), .r1_done(r1_done[0]), .r1_err(r1_err[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]), .alu_z(alu_z[0]),
    .busy(busy[0])
  );

  alu_arbiter #(.ALU_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready[1]), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
    .r0_z(r0_z[1]), .r0_done(r0_done[1]), .r0_err(r0_err[1]),
    .r1_valid(r1_valid), .r1_ready(r1_ready[1]), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
    .r1_z(r1_z[1]), .r1_done(r1_done[1]), .r1_err(r1_err[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]), .alu_z(alu_z[1]),
    .busy(busy[1])
  );

  // Transaction model: 'left' counts the busy cycles still ahead; the done cycle is left==1.
  int         lat [2] = '{1, 3};
  int         left [2];
  bit         owner [2];
  bit         last [2];
  logic [7:0] pz [2];
  bit         pe [2];
  logic [7:0] ez0 [2];
  logic [7:0] ez1 [2];
  bit         ee0 [2];
  bit         ee1 [2];
  logic [7:0] ea [2];
  logic [7:0] eb [2];
  logic [3:0] es [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    left[k] = 0; owner[k] = 1'b0; last[k] = 1'b1;
    pz[k] = 8'h00; pe[k] = 1'b0;
    ez0[k] = 8'h00; ez1[k] = 8'h00; ee0[k] = 1'b0; ee1[k] = 1'b0;
    ea[k] = 8'h00; eb[k] = 8'h00; es[k] = 4'h0;
  endtask

  function automatic bit model_grant(input int k);
    if (r0_valid && !r1_valid) return 1'b0;
    if (r1_valid && !r0_valid) return 1'b1;
    return !last[k];
  endfunction

  task automatic model_edge(input int k);
    int prev = left[k];
    bit g;
    if (left[k] > 0) begin
      left[k]--;
    end else begin
      g = model_grant(k);
      if (g ? r1_valid : r0_valid) begin
        ea[k] = g ? r1_a : r0_a;
        eb[k] = g ? r1_b : r0_b;
        es[k] = g ? r1_sel : r0_sel;
        owner[k] = g;
        last[k] = g;
        if (es[k] == 4'hF) begin
          pz[k] = 8'h00; pe[k] = 1'b1; left[k] = 1;
        end else begin
          pz[k] = alu_f(ea[k], eb[k], es[k]); pe[k] = 1'b0; left[k] = lat[k] + 1;
        end
      end
    end
    if (left[k] == 1 && prev != 1) begin
      if (owner[k]) begin ez1[k] = pz[k]; ee1[k] = pe[k]; end
      else          begin ez0[k] = pz[k]; ee0[k] = pe[k]; end
    end
  endtask

  task automatic compare_all(input int k);
    string p = (k == 0) ? "lat1" : "lat3";
    bit g = model_grant(k);
    bit idle = (left[k] == 0);
    if (r0_valid) check({p, "_r0_ready"}, r0_ready[k], idle && !g);
    if (r1_valid) check({p, "_r1_ready"}, r1_ready[k], idle && g);
    check({p, "_one_ready"}, r0_ready[k] & r1_ready[k], 0);
    check({p, "_busy"},    busy[k],    !idle);
    check({p, "_r0_done"}, r0_done[k], left[k] == 1 && !owner[k]);
    check({p, "_r1_done"}, r1_done[k], left[k] == 1 &&  owner[k]);
    check({p, "_r0_z"},    r0_z[k],    ez0[k]);
    check({p, "_r1_z"},    r1_z[k],    ez1[k]);
    check({p, "_r0_err"},  r0_err[k],  ee0[k]);
    check({p, "_r1_err"},  r1_err[k],  ee1[k]);
    check({p, "_alu_a"},   alu_a[k],   ea[k]);
    check({p, "_alu_b"},   alu_b[k],   eb[k]);
    check({p, "_alu_sel"}, alu_sel[k], es[k]);
  endtask

  task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [3:0] s0, input logic v1, input logic [7:0] a1,
                       input logic [7:0] b1, input logic [3:0] s1);
    r0_valid = v0; r0_a = a0; r0_b = b0; r0_sel = s0;
    r1_valid = v1; r1_a = a1; r1_b = b1; r1_sel = s1;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle();
    #1;
    compare_all(0);
    compare_all(1);
    @(posedge clk);
    if (rst_n) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all(0);
    compare_all(1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int c0, c1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    #1;
    compare_all(0);
    compare_all(1);
    rst_n = 1'b1;

    // Single legal r0 add: done two cycles after accept at ALU_LAT=1.
    drive(1, 8'h05, 8'h03, 4'h0, 0, 0, 0, 0);
    cycle();
    check("A_busy", busy[0], 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("A_r0_done", r0_done[0], 1);
    check("A_r0_z", r0_z[0], 8'h08);
    check("A_r0_err", r0_err[0], 0);
    check("A_r1_z", r1_z[0], 8'h00);
    idle_cycles(4);

    // Both valid from reset: r0 first, then strict alternation.
    do_reset();
    drive(1, 8'h01, 8'h01, 4'h0, 1, 8'hF0, 8'hFF, 4'hA);
    #1;
    check("B_first_r0", r0_ready[0], 1);
    check("B_first_r1", r1_ready[0], 0);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      c0 += int'(r0_done[0]);
      c1 += int'(r1_done[0]);
    end
    check("B_r0_dones", c0, 2);
    check("B_r1_dones", c1, 2);
    check("B_r0_z", r0_z[0], 8'h02);
    check("B_r1_z", r1_z[0], 8'h0F);
    idle_cycles(6);

    // Illegal opcode from r1, then a legal r1 op clears the error.
    do_reset();
    drive(0, 0, 0, 0, 1, 8'h12, 8'h34, 4'hF);
    cycle();
    check("C_r1_done", r1_done[0], 1);
    check("C_r1_done_l3", r1_done[1], 1);
    check("C_r1_z", r1_z[0], 8'h00);
    check("C_r1_err", r1_err[0], 1);
    check("C_alu_sel", alu_sel[0], 4'hF);
    drive(0, 0, 0, 0, 1, 8'h02, 8'h03, 4'h0);
    repeat (3) cycle();
    check("C2_r1_done", r1_done[0], 1);
    check("C2_r1_z", r1_z[0], 8'h05);
    check("C2_r1_err", r1_err[0], 0);
    idle_cycles(6);

    // ALU_LAT=3 multiply with truncation; inputs stable and ready low through EXEC/DONE.
    do_reset();
    drive(1, 8'h10, 8'h20, 4'h3, 0, 0, 0, 0);
    cycle();
    for (int i = 1; i <= 3; i++) begin
      check("D_alu_a", alu_a[1], 8'h10);
      check("D_alu_b", alu_b[1], 8'h20);
      check("D_alu_sel", alu_sel[1], 4'h3);
      check("D_ready_low", r0_ready[1], 0);
      check("D_no_done", r0_done[1], 0);
      cycle();
    end
    check("D_r0_done", r0_done[1], 1);
    check("D_r0_z", r0_z[1], 8'h00);
    check("D_ready_done", r0_ready[1], 0);
    cycle();
    check("D_ready_after", r0_ready[1], 1);
    idle_cycles(6);

    // Reset in the middle of an r1 EXEC: no done, everything cleared, r0 wins afterwards.
    do_reset();
    drive(0, 0, 0, 0, 1, 8'h07, 8'h08, 4'h0);
    cycle();
    check("E_in_exec", busy[1], 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    check("E_busy", busy, 2'b00);
    check("E_r1_done", r1_done, 2'b00);
    check("E_alu_a", alu_a[1], 8'h00);
    check("E_r1_z", r1_z[1], 8'h00);
    idle_cycles(4);
    drive(1, 8'h11, 8'h22, 4'h4, 1, 8'h33, 8'h44, 4'h2);
    #1;
    check("E_grant_r0", r0_ready[0], 1);
    check("E_grant_r0_l3", r0_ready[1], 1);
    cycle();
    idle_cycles(6);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      if (i % 397 == 396) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
